// File: rtl/data_mem_resp_if.sv
// Load/store access bus between the core's memory controller (master) and the
// data-memory responder (slave).
interface data_mem_resp_if;
  // Handshake: the master may raise require_mem_access with write/size/addr/wdata
  // at any time; the request is taken on a rising edge where data_mem_ready_n=0.
  // Requests seen while data_mem_ready_n=1 are dropped, not queued. Each taken
  // request produces exactly one rdata_valid pulse (access_err marks rejection).
  logic        require_mem_access;
  logic        write_to_data_mem;
  logic [1:0]  access_size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        data_mem_ready_n;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        access_err;

  modport master (
    output require_mem_access, write_to_data_mem, access_size, addr, wdata,
    input  data_mem_ready_n, rdata, rdata_valid, access_err
  );

  modport slave (
    input  require_mem_access, write_to_data_mem, access_size, addr, wdata,
    output data_mem_ready_n, rdata, rdata_valid, access_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: word-organised on-chip array with programmable wait states.
// Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned half/word accesses.
module data_mem_resp #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_resp_if.slave  bus,
  output logic            dbg_state
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                accept, do_access;

  logic                lat_write;
  logic [1:0]          lat_size;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_wdata;

  logic                op_write;
  logic [1:0]          op_size;
  logic [ADDR_W-1:0]   op_addr;
  logic [31:0]         op_wdata;

  logic                op_err;
  logic [ADDR_W-1:0]   eff_addr;
  logic [ADDR_W-3:0]   word_idx;
  logic [3:0]          byte_en;
  logic [31:0]         lane_data;
  logic [31:0]         rword;
  logic [31:0]         load_data;

  logic [31:0]         rdata_q;
  logic                valid_q;
  logic                err_q;
  logic                unused_addr;

  logic [31:0]         mem [DEPTH];

  assign accept      = (state_q == IDLE) && bus.require_mem_access;
  assign unused_addr = ^bus.addr[31:ADDR_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_size  <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= bus.write_to_data_mem;
      lat_size  <= bus.access_size;
      lat_addr  <= bus.addr[ADDR_W-1:0];
      lat_wdata <= bus.wdata;
    end
  end

  // With no wait states the access happens on the accept edge itself.
  assign op_write = (WAIT_CYCLES == 0) ? bus.write_to_data_mem    : lat_write;
  assign op_size  = (WAIT_CYCLES == 0) ? bus.access_size          : lat_size;
  assign op_addr  = (WAIT_CYCLES == 0) ? bus.addr[ADDR_W-1:0]     : lat_addr;
  assign op_wdata = (WAIT_CYCLES == 0) ? bus.wdata                : lat_wdata;

  always_comb begin
    eff_addr  = op_addr;
    op_err    = (op_size == 2'b11);
    byte_en   = 4'b0000;
    lane_data = 32'h0;
    load_data = 32'h0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (op_size == 2'b01 && op_addr[0])          op_err = 1'b1;
    if (op_size == 2'b00 && op_addr[1:0] != 2'b00) op_err = 1'b1;
`else
    if (op_size == 2'b01) eff_addr[0]   = 1'b0;
    if (op_size == 2'b00) eff_addr[1:0] = 2'b00;
`endif
    word_idx = eff_addr[ADDR_W-1:2];
    rword    = mem[word_idx];
    case (op_size)
      2'b00: begin
        byte_en   = 4'b1111;
        lane_data = op_wdata;
        load_data = rword;
      end
      2'b01: begin
        byte_en   = eff_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{op_wdata[15:0]}};
        load_data = {16'h0, (eff_addr[1] ? rword[31:16] : rword[15:0])};
      end
      2'b10: begin
        byte_en   = 4'b0001 << eff_addr[1:0];
        lane_data = {4{op_wdata[7:0]}};
        load_data = {24'h0, rword[{eff_addr[1:0], 3'b000} +: 8]};
      end
      default: ;
    endcase
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_access && op_write && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= do_access;
      err_q   <= do_access && op_err;
      if (do_access) rdata_q <= (op_write || op_err) ? 32'h0 : load_data;
    end
  end

  assign bus.data_mem_ready_n = (state_q == BUSY);
  assign bus.rdata            = rdata_q;
  assign bus.rdata_valid      = valid_q;
  assign bus.access_err       = err_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: a 2-wait-state instance checked against a byte-addressed
// reference memory, plus a zero-wait-state instance for single-cycle throughput.
module tb_data_mem_resp;
  localparam int ADDR_W = 12;
  localparam int W      = 2;

  logic clk = 1'b0;
  logic rst;
  logic dbg2, dbg0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0]  ref_mem [1 << ADDR_W];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  data_mem_resp_if b2();
  data_mem_resp_if b0();

  data_mem_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave), .dbg_state(dbg2));
  data_mem_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave), .dbg_state(dbg0));

  // Reference model: byte-addressed little-endian memory.
  task automatic model(input bit wr, input logic [1:0] sz, input logic [31:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int a, n;
    rd  = 32'h0;
    a   = int'(ad[ADDR_W-1:0]);
    err = (sz == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sz == 2'b01 && (a % 2) != 0) err = 1'b1;
    if (sz == 2'b00 && (a % 4) != 0) err = 1'b1;
`endif
    if (err) return;
    n = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    a = a - (a % n);
    for (int i = 0; i < n; i++) begin
      if (wr) ref_mem[a + i] = wd[8*i +: 8];
      else    rd[8*i +: 8]   = ref_mem[a + i];
    end
  endtask

  task automatic drive2(input bit wr, input logic [1:0] sz, input logic [31:0] ad,
                        input logic [31:0] wd, output logic [31:0] rd, output bit err,
                        output int lat, output int busy, output bit tail_clean);
    bit got = 1'b0;
    rd = 32'h0; err = 1'b0; lat = 0; busy = 0;
    @(negedge clk);
    b2.require_mem_access = 1'b1;
    b2.write_to_data_mem  = wr;
    b2.access_size        = sz;
    b2.addr               = ad;
    b2.wdata              = wd;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        b2.require_mem_access = 1'b0;
        b2.write_to_data_mem  = 1'($urandom);
        b2.access_size        = 2'($urandom_range(3));
        b2.addr               = $urandom;
        b2.wdata              = $urandom;
      end
      if (b2.data_mem_ready_n) busy++;
      if (b2.rdata_valid) begin
        got = 1'b1; lat = k; rd = b2.rdata; err = b2.access_err;
      end
    end
    @(negedge clk);
    tail_clean = !b2.rdata_valid && !b2.access_err;
  endtask

  task automatic test_reset();
    logic [31:0] rd, ex; bit err, exe, tc; int lat, busy;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({b2.data_mem_ready_n, b2.rdata, b2.rdata_valid, b2.access_err, dbg2} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy_n=%b rdata=%h v=%b e=%b st=%b exp all 0",
               b2.data_mem_ready_n, b2.rdata, b2.rdata_valid, b2.access_err, dbg2);
    end
    rst = 1'b0;
    model(1'b1, 2'b00, 32'h10, 32'h11223344, ex, exe);
    drive2(1'b1, 2'b00, 32'h10, 32'h11223344, rd, err, lat, busy, tc);
    model(1'b0, 2'b00, 32'h10, 32'h0, ex, exe);
    drive2(1'b0, 2'b00, 32'h10, 32'h0, rd, err, lat, busy, tc);
    n_checks++;
    if (rd !== 32'h11223344) begin
      n_fail++; $display("FAIL reset_preload got %h exp %h", rd, 32'h11223344);
    end
    @(negedge clk);
    b2.require_mem_access = 1'b1; b2.write_to_data_mem = 1'b1;
    b2.access_size = 2'b00; b2.addr = 32'h10; b2.wdata = 32'hCAFEBABE;
    @(negedge clk);
    b2.require_mem_access = 1'b0;
    n_checks++;
    if (b2.data_mem_ready_n !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy_before got %b exp 1", b2.data_mem_ready_n);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({b2.data_mem_ready_n, b2.rdata, b2.rdata_valid, b2.access_err, dbg2} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_mid_busy got rdy_n=%b rdata=%h v=%b e=%b st=%b exp all 0",
               b2.data_mem_ready_n, b2.rdata, b2.rdata_valid, b2.access_err, dbg2);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive2(1'b0, 2'b00, 32'h10, 32'h0, rd, err, lat, busy, tc);
    n_checks++;
    if (rd !== 32'h11223344 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_aborted_store got %h err %b exp %h err 0", rd, err, 32'h11223344);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd, ex; bit err, exe, tc; int lat, busy;
    model(1'b1, 2'b00, 32'h20, 32'hDEADBEEF, ex, exe);
    drive2(1'b1, 2'b00, 32'h20, 32'hDEADBEEF, rd, err, lat, busy, tc);
    n_checks++;
    if (busy !== W || lat !== W + 1 || rd !== 32'h0 || !tc) begin
      n_fail++; $display("FAIL word_store busy=%0d lat=%0d rdata=%h tail=%b exp %0d %0d 0 1",
                         busy, lat, rd, tc, W, W + 1);
    end
    model(1'b0, 2'b00, 32'h20, 32'h0, ex, exe);
    drive2(1'b0, 2'b00, 32'h20, 32'h0, rd, err, lat, busy, tc);
    n_checks++;
    if (busy !== W || lat !== W + 1 || rd !== 32'hDEADBEEF || err || !tc) begin
      n_fail++; $display("FAIL word_load busy=%0d lat=%0d rdata=%h err=%b tail=%b exp rdata %h",
                         busy, lat, rd, err, tc, 32'hDEADBEEF);
    end
  endtask

  task automatic test_sub_word();
    logic [31:0] rd, ex; bit err, exe, tc; int lat, busy;
    logic [31:0] wb, wh;
    wb = {24'($urandom), 8'hA5};
    wh = {16'($urandom), 16'h1234};
    model(1'b1, 2'b00, 32'h20, 32'h0, ex, exe);
    drive2(1'b1, 2'b00, 32'h20, 32'h0, rd, err, lat, busy, tc);
    model(1'b1, 2'b10, 32'h23, wb, ex, exe);
    drive2(1'b1, 2'b10, 32'h23, wb, rd, err, lat, busy, tc);
    model(1'b1, 2'b01, 32'h20, wh, ex, exe);
    drive2(1'b1, 2'b01, 32'h20, wh, rd, err, lat, busy, tc);
    drive2(1'b0, 2'b00, 32'h20, 32'h0, rd, err, lat, busy, tc);
    n_checks++;
    if (rd !== 32'hA5001234) begin
      n_fail++; $display("FAIL subword_word_load got %h exp %h", rd, 32'hA5001234);
    end
    drive2(1'b0, 2'b10, 32'h23, 32'h0, rd, err, lat, busy, tc);
    n_checks++;
    if (rd !== 32'h000000A5) begin
      n_fail++; $display("FAIL subword_byte_load got %h exp %h", rd, 32'h000000A5);
    end
    drive2(1'b0, 2'b01, 32'h22, 32'h0, rd, err, lat, busy, tc);
    n_checks++;
    if (rd !== 32'h0000A500) begin
      n_fail++; $display("FAIL subword_half_load got %h exp %h", rd, 32'h0000A500);
    end
  endtask

  task automatic test_size_err();
    logic [31:0] rd, ex, wd; bit err, exe, tc; int lat, busy;
    wd = $urandom;
    model(1'b1, 2'b00, 32'h30, wd, ex, exe);
    drive2(1'b1, 2'b00, 32'h30, wd, rd, err, lat, busy, tc);
    model(1'b1, 2'b11, 32'h30, ~wd, ex, exe);
    drive2(1'b1, 2'b11, 32'h30, ~wd, rd, err, lat, busy, tc);
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== W + 1 || !tc) begin
      n_fail++; $display("FAIL size_err err=%b rdata=%h lat=%0d tail=%b exp 1 0 %0d 1", err, rd, lat, tc, W + 1);
    end
    drive2(1'b0, 2'b00, 32'h30, 32'h0, rd, err, lat, busy, tc);
    n_checks++;
    if (rd !== wd || err !== 1'b0) begin
      n_fail++; $display("FAIL size_err_unchanged got %h err %b exp %h err 0", rd, err, wd);
    end
  endtask

  task automatic test_align();
    logic [31:0] rd, ex; bit err, exe, tc; int lat, busy;
    model(1'b1, 2'b00, 32'h20, 32'h55667788, ex, exe);
    drive2(1'b1, 2'b00, 32'h20, 32'h55667788, rd, err, lat, busy, tc);
    drive2(1'b0, 2'b00, 32'h22, 32'h0, rd, err, lat, busy, tc);
`ifdef DMEM_ALIGN_CHECK_EN
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== W + 1) begin
      n_fail++; $display("FAIL align_word err=%b rdata=%h lat=%0d exp 1 0 %0d", err, rd, lat, W + 1);
    end
`else
    n_checks++;
    if (err !== 1'b0 || rd !== 32'h55667788) begin
      n_fail++; $display("FAIL align_word err=%b rdata=%h exp 0 %h", err, rd, 32'h55667788);
    end
`endif
    model(1'b0, 2'b01, 32'h21, 32'h0, ex, exe);
    drive2(1'b0, 2'b01, 32'h21, 32'h0, rd, err, lat, busy, tc);
    n_checks++;
    if (err !== exe || rd !== ex) begin
      n_fail++; $display("FAIL align_half err=%b rdata=%h exp %b %h", err, rd, exe, ex);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad [3], wd [3], ex;
    logic [1:0]  sz [3];
    bit          wr [3];
    bit          exe;
    int          issued, done, busy;
    wr = '{1'b1, 1'b0, 1'b0};
    sz = '{2'b00, 2'b00, 2'b10};
    ad = '{32'h80, 32'h80, 32'h81};
    wd = '{$urandom, $urandom, $urandom};
    exp_q.delete();
    @(negedge clk);
    b2.require_mem_access = 1'b1;
    b2.write_to_data_mem = wr[0]; b2.access_size = sz[0]; b2.addr = ad[0]; b2.wdata = wd[0];
    model(wr[0], sz[0], ad[0], wd[0], ex, exe); exp_q.push_back(ex);
    issued = 1; done = 0; busy = 0;
    for (int k = 1; k <= 15 && done < 3; k++) begin
      @(negedge clk);
      if (b2.data_mem_ready_n) busy++;
      if (b2.rdata_valid) begin
        ex = exp_q.pop_front();
        n_checks++;
        if (b2.rdata !== ex || k !== (W + 1) * (done + 1)) begin
          n_fail++; $display("FAIL b2b_op%0d rdata=%h cycle=%0d exp %h cycle %0d",
                             done, b2.rdata, k, ex, (W + 1) * (done + 1));
        end
        done++;
        if (issued < 3) begin
          b2.write_to_data_mem = wr[issued]; b2.access_size = sz[issued];
          b2.addr = ad[issued]; b2.wdata = wd[issued];
          model(wr[issued], sz[issued], ad[issued], wd[issued], ex, exe); exp_q.push_back(ex);
          issued++;
        end else begin
          b2.require_mem_access = 1'b0;
        end
      end
    end
    b2.require_mem_access = 1'b0;
    n_checks++;
    if (done !== 3 || busy !== 3 * W) begin
      n_fail++; $display("FAIL b2b_count done=%0d busy=%0d exp 3 %0d", done, busy, 3 * W);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] ad [4], wd [4], ex [4];
    logic [1:0]  sz [4];
    bit          wr [4];
    wr = '{1'b1, 1'b0, 1'b1, 1'b0};
    sz = '{2'b00, 2'b00, 2'b10, 2'b10};
    ad = '{32'h40, 32'h40, 32'h47, 32'h47};
    wd = '{32'hA1B2C3D4, $urandom, {24'($urandom), 8'h5A}, $urandom};
    ex = '{32'h0, 32'hA1B2C3D4, 32'h0, 32'h5A};
    @(negedge clk);
    b0.require_mem_access = 1'b1;
    b0.write_to_data_mem = wr[0]; b0.access_size = sz[0]; b0.addr = ad[0]; b0.wdata = wd[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (b0.data_mem_ready_n !== 1'b0 || b0.rdata_valid !== 1'b1 || b0.rdata !== ex[i] || b0.access_err !== 1'b0) begin
        n_fail++; $display("FAIL zero_wait_op%0d rdy_n=%b v=%b rdata=%h e=%b exp 0 1 %h 0",
                           i, b0.data_mem_ready_n, b0.rdata_valid, b0.rdata, b0.access_err, ex[i]);
      end
      if (i < 3) begin
        b0.write_to_data_mem = wr[i+1]; b0.access_size = sz[i+1];
        b0.addr = ad[i+1]; b0.wdata = wd[i+1];
      end else begin
        b0.require_mem_access = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (b0.rdata_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_wait_tail v=%b exp 0", b0.rdata_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, ex, ad, wd; bit err, exe, tc, wr; logic [1:0] sz; int lat, busy;
    for (int i = 0; i < (1 << (ADDR_W - 2)); i++) begin
      wd = $urandom;
      model(1'b1, 2'b00, 32'(i * 4), wd, ex, exe);
      drive2(1'b1, 2'b00, 32'(i * 4), wd, rd, err, lat, busy, tc);
    end
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom); sz = 2'($urandom_range(3)); ad = $urandom; wd = $urandom;
      model(wr, sz, ad, wd, ex, exe);
      drive2(wr, sz, ad, wd, rd, err, lat, busy, tc);
      n_checks++;
      if (rd !== ex || err !== exe || lat !== W + 1 || busy !== W || !tc) begin
        n_fail++; $display("FAIL random_%0d wr=%b sz=%b addr=%h rdata=%h err=%b lat=%0d busy=%0d tail=%b exp %h %b",
                           i, wr, sz, ad, rd, err, lat, busy, tc, ex, exe);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    b2.require_mem_access = 1'b0; b2.write_to_data_mem = 1'b0;
    b2.access_size = 2'b00; b2.addr = 32'h0; b2.wdata = 32'h0;
    b0.require_mem_access = 1'b0; b0.write_to_data_mem = 1'b0;
    b0.access_size = 2'b00; b0.addr = 32'h0; b0.wdata = 32'h0;
    test_reset();
    test_word();
    test_sub_word();
    test_size_err();
    test_align();
    test_back_to_back();
    test_zero_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
